usb_rx_token: RTL and testbench

Full-speed USB token/SOF packet receiver. It samples the `vp`/`vm` line pair on a per-bit strobe, performs NRZI decoding and bit-unstuffing, and locks onto SYNC. It then checks the PID and CRC5, and reports the decoded 11-bit token field (frame number for SOF, {endp,addr} for IN/OUT/SETUP). It sits on the bus side opposite the SOF transmitter, so it can be used for loopback and bus monitoring in the motor-controller FPGA.

---
 rtl/usb_pkg.sv | 42 ++++
 rtl/usb_rx_nrzi.sv | 62 ++++++
 rtl/usb_rx_token.sv | 230 +++++++++++++++++++++++
 tb/tb_usb_rx_token.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed token receiver.
// PID codes, line-state encodings, CRC5 constants, FSM states and a CRC5 step helper.
package usb_pkg;

  // Token PIDs (PID[3:0]); the upper nibble on the wire is the complement.
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  // Line states encoded as {vp, vm}; SE1 (2'b11) is folded into SE0 by the decoder.
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;

  // CRC5 x^5+x^2+1, register bit 4 is the x^4 term and is shifted out first.
  localparam logic [4:0] CRC5_POLY   = 5'b00101;
  localparam logic [4:0] CRC5_PRESET = 5'b11111;
  localparam logic [4:0] RESIDUAL    = 5'b01100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_EOP,
    ST_WAIT_EOP
  } rx_state_e;

  // One serial CRC5 step for a single received bit.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

  // True for the four token PIDs this receiver accepts.
  function automatic logic is_token_pid(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_rx_nrzi.sv
// NRZI decoder and bit-unstuffer for the token receiver.
// Outputs are combinational views of the current strobed line sample.
module usb_rx_nrzi
  import usb_pkg::*;
(
  input  logic c,
  input  logic rst,
  input  logic bit_en,
  input  logic unstuff_en,
  input  logic vp,
  input  logic vm,
  output logic bit_out,
  output logic bit_valid,
  output logic se0,
  output logic stuff_err,
  output logic is_k
);

  logic [1:0] line_st;
  logic       prev_k_q, prev_k_d;
  logic [2:0] ones_q, ones_d;

  assign line_st = {vp, vm};
  assign is_k    = (line_st == LINE_K);
  assign se0     = (line_st != LINE_K) && (line_st != LINE_J);
  assign bit_out = !se0 && (is_k == prev_k_q);

  // Track the previous line state and count consecutive ones to find stuffed bits.
  always_comb begin
    prev_k_d  = prev_k_q;
    ones_d    = ones_q;
    bit_valid = 1'b0;
    stuff_err = 1'b0;
    if (bit_en) begin
      prev_k_d  = is_k;
      bit_valid = !se0;
      if (se0 || !unstuff_en) begin
        ones_d = 3'd0;
      end else if (ones_q == 3'd6) begin
        bit_valid = 1'b0;
        stuff_err = bit_out;
        ones_d    = 3'd0;
      end else if (bit_out) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = 3'd0;
      end
    end
  end

  // Decoder state registers; previous state resets to J.
  always_ff @(posedge c) begin
    if (rst) begin
      prev_k_q <= 1'b0;
      ones_q   <= 3'd0;
    end else begin
      prev_k_q <= prev_k_d;
      ones_q   <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_token.sv
// Full-speed USB token/SOF receiver: SYNC lock, PID check, 11-bit field and CRC5 check.
// Optional feature macro: USB_RX_TOKEN_CRC5_CHECK_EN enables the CRC5 residual check.
module usb_rx_token
  import usb_pkg::*;
(
  input  logic        c,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        vp,
  input  logic        vm,
  output logic        tok_valid,
  output logic        tok_err,
  output logic [3:0]  pid,
  output logic [10:0] tok_data,
  output logic        busy
);

  logic rx_bit, bit_valid, se0, stuff_err, is_k, is_j, unstuff_en, crc_ok;

  rx_state_e   state_q, state_d;
  logic [7:0]  sync_q, sync_d, sync_next;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  pid_sh_q, pid_sh_d, pid_next;
  logic [10:0] data_q, data_d;
  logic [1:0]  eop_cnt_q, eop_cnt_d;
  logic        se0_seen_q, se0_seen_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] tok_data_q, tok_data_d;
  logic        tok_valid_q, tok_valid_d;
  logic        tok_err_q, tok_err_d;
  logic        busy_q, busy_d;

  usb_rx_nrzi u_nrzi (
    .c          (c),
    .rst        (rst),
    .bit_en     (bit_en),
    .unstuff_en (unstuff_en),
    .vp         (vp),
    .vm         (vm),
    .bit_out    (rx_bit),
    .bit_valid  (bit_valid),
    .se0        (se0),
    .stuff_err  (stuff_err),
    .is_k       (is_k)
  );

  assign is_j       = !se0 && !is_k;
  assign unstuff_en = (state_q == ST_PID) || (state_q == ST_DATA) || (state_q == ST_EOP);
  assign sync_next  = {rx_bit, sync_q[7:1]};
  assign pid_next   = {rx_bit, pid_sh_q[7:1]};

`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
  logic [4:0] crc_q, crc_d;
  assign crc_ok = (crc_q == RESIDUAL);
`else
  assign crc_ok = 1'b1;
`endif

  assign tok_valid = tok_valid_q;
  assign tok_err   = tok_err_q;
  assign pid       = pid_q;
  assign tok_data  = tok_data_q;
  assign busy      = busy_q;

  // Packet state machine: advances one decoded bit per bit_en strobe.
  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    cnt_d       = cnt_q;
    pid_sh_d    = pid_sh_q;
    data_d      = data_q;
    eop_cnt_d   = eop_cnt_q;
    se0_seen_d  = se0_seen_q;
    pid_d       = pid_q;
    tok_data_d  = tok_data_q;
    tok_valid_d = 1'b0;
    tok_err_d   = 1'b0;
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
    crc_d       = crc_q;
`endif
    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_k) begin
            state_d = ST_SYNC;
            sync_d  = 8'b0111_1111;
            cnt_d   = 5'd1;
          end
        end
        ST_SYNC: begin
          if (se0) begin
            state_d    = ST_WAIT_EOP;
            se0_seen_d = 1'b1;
          end else begin
            sync_d = sync_next;
            cnt_d  = cnt_q + 5'd1;
            if (sync_next == 8'b1000_0000) begin
              state_d = ST_PID;
              cnt_d   = 5'd0;
            end else if (cnt_q >= 5'd10) begin
              state_d    = ST_WAIT_EOP;
              se0_seen_d = 1'b0;
            end
          end
        end
        ST_PID: begin
          if (se0 || stuff_err) begin
            tok_err_d  = 1'b1;
            state_d    = ST_WAIT_EOP;
            se0_seen_d = se0;
          end else if (bit_valid) begin
            pid_sh_d = pid_next;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = 5'd0;
              if (pid_next[7:4] != ~pid_next[3:0]) begin
                tok_err_d  = 1'b1;
                state_d    = ST_WAIT_EOP;
                se0_seen_d = 1'b0;
              end else if (!is_token_pid(pid_next[3:0])) begin
                state_d    = ST_WAIT_EOP;
                se0_seen_d = 1'b0;
              end else begin
                state_d = ST_DATA;
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
                crc_d   = CRC5_PRESET;
`endif
              end
            end
          end
        end
        ST_DATA: begin
          if (se0 || stuff_err) begin
            tok_err_d  = 1'b1;
            state_d    = ST_WAIT_EOP;
            se0_seen_d = se0;
          end else if (bit_valid) begin
            if (cnt_q < 5'd11) begin
              data_d = {rx_bit, data_q[10:1]};
            end
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
            crc_d = crc5_step(crc_q, rx_bit);
`endif
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              state_d   = ST_EOP;
              eop_cnt_d = 2'd0;
            end
          end
        end
        ST_EOP: begin
          if (eop_cnt_q < 2'd2) begin
            if (se0) begin
              eop_cnt_d = eop_cnt_q + 2'd1;
            end else if (!bit_valid && !stuff_err) begin
              eop_cnt_d = eop_cnt_q;
            end else begin
              tok_err_d  = 1'b1;
              state_d    = ST_WAIT_EOP;
              se0_seen_d = 1'b0;
            end
          end else if (is_j) begin
            state_d = ST_IDLE;
            if (crc_ok) begin
              tok_valid_d = 1'b1;
              pid_d       = pid_sh_q[3:0];
              tok_data_d  = data_q;
            end else begin
              tok_err_d = 1'b1;
            end
          end else begin
            tok_err_d  = 1'b1;
            state_d    = ST_WAIT_EOP;
            se0_seen_d = se0;
          end
        end
        ST_WAIT_EOP: begin
          if (se0) begin
            se0_seen_d = 1'b1;
          end else if (se0_seen_q && is_j) begin
            state_d    = ST_IDLE;
            se0_seen_d = 1'b0;
          end else begin
            se0_seen_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // All receiver state and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sync_q      <= 8'd0;
      cnt_q       <= 5'd0;
      pid_sh_q    <= 8'd0;
      data_q      <= 11'd0;
      eop_cnt_q   <= 2'd0;
      se0_seen_q  <= 1'b0;
      pid_q       <= 4'd0;
      tok_data_q  <= 11'd0;
      tok_valid_q <= 1'b0;
      tok_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
      crc_q       <= CRC5_PRESET;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      pid_sh_q    <= pid_sh_d;
      data_q      <= data_d;
      eop_cnt_q   <= eop_cnt_d;
      se0_seen_q  <= se0_seen_d;
      pid_q       <= pid_d;
      tok_data_q  <= tok_data_d;
      tok_valid_q <= tok_valid_d;
      tok_err_q   <= tok_err_d;
      busy_q      <= busy_d;
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_rx_token.sv
// Scoreboard testbench for usb_rx_token: packets are NRZI/bit-stuff encoded here,
// expected pulses are queued at issue time and a negedge monitor pops and compares them.
module tb_usb_rx_token;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  typedef struct {
    logic        isErr;
    logic [3:0]  pid;
    logic [10:0] data;
  } exp_t;

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        vp = 1'b1;
  logic        vm = 1'b0;
  logic        tok_valid, tok_err, busy;
  logic [3:0]  pid;
  logic [10:0] tok_data;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          gap = 1;
  logic [3:0]  expPid = 4'd0;
  logic [10:0] expData = 11'd0;

  usb_rx_token dut (
    .c         (c),
    .rst       (rst),
    .bit_en    (bit_en),
    .vp        (vp),
    .vm        (vm),
    .tok_valid (tok_valid),
    .tok_err   (tok_err),
    .pid       (pid),
    .tok_data  (tok_data),
    .busy      (busy)
  );

  // Free-running system clock.
  always #5 c = ~c;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Transmit-side CRC5 of an 11-bit field: complement of the register, bit 4 sent first.
  function automatic logic [4:0] crc5Tx(input logic [10:0] d);
    logic [4:0] r;
    logic       fb;
    r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return ~r;
  endfunction

  // Present one line state for one bit period of 'gap' clocks.
  task automatic driveLine(input logic [1:0] ln);
    @(negedge c);
    {vp, vm} = ln;
    bit_en   = 1'b1;
    for (int i = 1; i < gap; i++) begin
      @(negedge c);
      bit_en = 1'b0;
    end
  endtask

  // One-cycle reset in the middle of traffic; every output must return to zero.
  task automatic pulseReset();
    @(negedge c);
    bit_en = 1'b0;
    rst    = 1'b1;
    @(negedge c);
    rst     = 1'b0;
    expPid  = 4'd0;
    expData = 11'd0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pid", 32'(pid), 32'd0);
    checkOutput("rst_tok_data", 32'(tok_data), 32'd0);
    checkOutput("rst_tok_valid", 32'(tok_valid), 32'd0);
    checkOutput("rst_tok_err", 32'(tok_err), 32'd0);
  endtask

  // Encode and send SYNC, PID, field and CRC5 (optionally corrupted/unstuffed), then EOP.
  task automatic applyStimulus(input logic [7:0] pidByte, input logic [10:0] field,
                               input logic [4:0] crcXor, input bit noStuff, input int rstAt);
    logic       raw[$];
    logic       coded[$];
    logic [4:0] crc;
    logic       level;
    int         ones;
    for (int i = 0; i < 8; i++) raw.push_back(pidByte[i]);
    for (int i = 0; i < 11; i++) raw.push_back(field[i]);
    crc = crc5Tx(field) ^ crcXor;
    for (int i = 4; i >= 0; i--) raw.push_back(crc[i]);
    for (int i = 0; i < 7; i++) coded.push_back(1'b0);
    coded.push_back(1'b1);
    ones = 0;
    foreach (raw[i]) begin
      coded.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (!noStuff && ones == 6) begin
        coded.push_back(1'b0);
        ones = 0;
      end
    end
    level = 1'b0;
    foreach (coded[i]) begin
      if (coded[i] == 1'b0) level = ~level;
      driveLine(level ? LK : LJ);
      if (i == rstAt) pulseReset();
    end
    driveLine(LSE0);
    driveLine(LSE0);
    for (int i = 0; i < 4; i++) driveLine(LJ);
    @(negedge c);
    bit_en = 1'b0;
  endtask

  // After a packet: every queued pulse must have been seen and the receiver idle.
  task automatic finishPacket(input string name);
    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge c);
    checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic expectValid(input logic [3:0] p, input logic [10:0] d);
    expPid  = p;
    expData = d;
    expQ.push_back('{isErr: 1'b0, pid: p, data: d});
  endtask

  task automatic expectErr();
    expQ.push_back('{isErr: 1'b1, pid: expPid, data: expData});
  endtask

  // Monitor: pop the scoreboard on every result pulse and compare.
  always @(negedge c) begin
    exp_t e;
    if (!rst && (tok_valid || tok_err)) begin
      checkOutput("pulse_exclusive", 32'(tok_valid & tok_err), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 32'({tok_valid, tok_err}), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_is_err", 32'(tok_err), 32'(e.isErr));
        checkOutput("pulse_pid", 32'(pid), 32'(e.pid));
        checkOutput("pulse_tok_data", 32'(tok_data), 32'(e.data));
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed packet sequence.
  initial begin
    repeat (3) @(negedge c);
    rst = 1'b0;
    @(negedge c);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pid", 32'(pid), 32'd0);
    checkOutput("reset_tok_data", 32'(tok_data), 32'd0);
    checkOutput("reset_pulses", 32'({tok_valid, tok_err}), 32'd0);

    $display("[TB] SOF 0x123, bit_en 1 in 10");
    gap = 10;
    expectValid(4'b0101, 11'h123);
    applyStimulus(8'hA5, 11'h123, 5'd0, 1'b0, -1);
    finishPacket("sof_123");

    $display("[TB] IN addr 7F endp F");
    gap = 1;
    expectValid(4'b1001, 11'h7FF);
    applyStimulus(8'h69, 11'h7FF, 5'd0, 1'b0, -1);
    finishPacket("in_7ff");

    $display("[TB] SOF 0x0AA with a corrupted CRC bit");
    gap = 2;
`ifdef USB_RX_TOKEN_CRC5_CHECK_EN
    expectErr();
`else
    expectValid(4'b0101, 11'h0AA);
`endif
    applyStimulus(8'hA5, 11'h0AA, 5'b00100, 1'b0, -1);
    finishPacket("sof_0aa_badcrc");

    $display("[TB] PID byte 0x55");
    gap = 1;
    expectErr();
    applyStimulus(8'h55, 11'h000, 5'd0, 1'b0, -1);
    finishPacket("pid_55");

    $display("[TB] DATA0 PID 0xC3");
    applyStimulus(8'hC3, 11'h000, 5'd0, 1'b0, -1);
    finishPacket("data0");

    $display("[TB] seven ones in the data field");
    expectErr();
    applyStimulus(8'hA5, 11'h07F, 5'd0, 1'b1, -1);
    finishPacket("stuff_err");

    $display("[TB] SOF 0x001");
    expectValid(4'b0101, 11'h001);
    applyStimulus(8'hA5, 11'h001, 5'd0, 1'b0, -1);
    finishPacket("sof_001");

    $display("[TB] reset during the data field");
    applyStimulus(8'hA5, 11'h7FF, 5'd0, 1'b0, 20);
    finishPacket("rst_mid");

    $display("[TB] SOF 0x7FF after reset");
    expectValid(4'b0101, 11'h7FF);
    applyStimulus(8'hA5, 11'h7FF, 5'd0, 1'b0, -1);
    finishPacket("sof_7ff");
    checkOutput("final_pid", 32'(pid), 32'h5);
    checkOutput("final_tok_data", 32'(tok_data), 32'h7FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
